game_tick_scheduler: RTL

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

---
 rtl/game_tick_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
// Frame-rate tick scheduler for a paddle/ball game: free-running frame prescaler
// plus an IDLE/RUN/SERVE/PAUSE controller gating paddle and ball update enables.
module game_tick_scheduler #(
   parameter int FRAME_DIV    = 833333,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       point_scored,
   input  logic       speed_up,
   output logic       frame_tick,
   output logic       paddle_tick,
   output logic       ball_tick,
   output logic [1:0] speed_level,
   output logic [1:0] state,
   output logic [7:0] serve_count
);

   localparam int             PW        = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
   localparam logic [PW-1:0]  PRE_MAX   = PW'(FRAME_DIV - 1);
   localparam logic [7:0]     SERVE_LD  = 8'(SERVE_FRAMES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SERVE = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t        state_reg;
   state_t        resume_reg;
   logic [PW-1:0] prescaler_reg;
   logic [1:0]    ball_cnt_reg;
   logic [1:0]    speed_reg;
   logic [7:0]    serve_reg;
   logic          frame_tick_reg;
   logic          paddle_tick_reg;
   logic          ball_tick_reg;

   logic wrap;
   logic ball_due;
   logic active;

   assign wrap     = (prescaler_reg == PRE_MAX);
   // Threshold 3-level shortens the ball period as the level rises.
   assign ball_due = (ball_cnt_reg >= (2'd3 - speed_reg));
   assign active   = (state_reg == RUN) || (state_reg == SERVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_reg   <= '0;
         ball_cnt_reg    <= '0;
         speed_reg       <= '0;
         serve_reg       <= '0;
         frame_tick_reg  <= 1'b0;
         paddle_tick_reg <= 1'b0;
         ball_tick_reg   <= 1'b0;
         state_reg       <= IDLE;
         resume_reg      <= IDLE;
      end else begin
         prescaler_reg   <= wrap ? '0 : prescaler_reg + 1'b1;
         frame_tick_reg  <= wrap;
         paddle_tick_reg <= wrap && active;
         ball_tick_reg   <= wrap && (state_reg == RUN) && ball_due;

         if (speed_up && active && (speed_reg != 2'd3))
            speed_reg <= speed_reg + 2'd1;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= SERVE;
                  serve_reg <= SERVE_LD;
                  speed_reg <= 2'd0;
               end
            end
            SERVE: begin
               // A pause landing on the expiring frame freezes the countdown.
               if (pause) begin
                  resume_reg <= SERVE;
                  state_reg  <= PAUSE;
               end else if (wrap) begin
                  if (serve_reg == 8'd1) begin
                     serve_reg    <= 8'd0;
                     ball_cnt_reg <= 2'd0;
                     state_reg    <= RUN;
                  end else begin
                     serve_reg <= serve_reg - 8'd1;
                  end
               end
            end
            RUN: begin
               if (point_scored) begin
                  state_reg <= SERVE;
                  serve_reg <= SERVE_LD;
               end else if (pause) begin
                  resume_reg <= RUN;
                  state_reg  <= PAUSE;
               end else if (wrap) begin
                  ball_cnt_reg <= ball_due ? 2'd0 : ball_cnt_reg + 2'd1;
               end
            end
            PAUSE: begin
               if (pause)
                  state_reg <= resume_reg;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign frame_tick  = frame_tick_reg;
   assign paddle_tick = paddle_tick_reg;
   assign ball_tick   = ball_tick_reg;
   assign speed_level = speed_reg;
   assign state       = state_reg;
   assign serve_count = serve_reg;

endmodule
